// File: rtl/flag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_pkg : shared colour constants and band-boundary helper for the      |
// |            flag stripe engine.                                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package flag_pkg;

    localparam int COLOR_W     = 6;
    localparam int IDX_W       = 3;
    localparam int POS_W       = 10;
    localparam int MAX_STRIPES = 8;

    localparam logic [COLOR_W-1:0] BLACK   = 6'b000000;
    localparam logic [COLOR_W-1:0] WHITE   = 6'b111111;
    localparam logic [COLOR_W-1:0] RED     = 6'b110000;
    localparam logic [COLOR_W-1:0] GREEN   = 6'b001100;
    localparam logic [COLOR_W-1:0] BLUE    = 6'b000011;
    localparam logic [COLOR_W-1:0] YELLOW  = 6'b111100;
    localparam logic [COLOR_W-1:0] CYAN    = 6'b001111;
    localparam logic [COLOR_W-1:0] MAGENTA = 6'b110011;
    localparam logic [COLOR_W-1:0] ORANGE  = 6'b110100;

    // First position of band k; only ever evaluated on constants.
    function automatic int START(input int span, input int num_stripes, input int k);
        return (span * k) / num_stripes;
    endfunction

endpackage : flag_pkg
`default_nettype wire

// File: rtl/flag_stripe_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_stripe_tracker : band index counter stepping at precomputed band    |
// |                       boundaries along the stripe axis.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module flag_stripe_tracker
    import flag_pkg::*;
#(
    parameter int NUM_STRIPES = 7,
    parameter int SPAN        = 480,
    parameter int VERTICAL    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] pix_x,
    input  logic [POS_W-1:0] pix_y,
    input  logic             line_start,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_STRIPES - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [POS_W-1:0] w_bound [MAX_STRIPES];
    logic [POS_W-1:0] w_next_bound;
    logic             w_can_step;
    logic             w_hit_h;
    logic             w_hit_v;

    // w_bound[k] holds START(k+1); entries past the last band are never reached.
    for (genvar k = 0; k < MAX_STRIPES; k++) begin : g_bound
        if (k + 1 < NUM_STRIPES) begin : g_live
            assign w_bound[k] = POS_W'(START(SPAN, NUM_STRIPES, k + 1));
        end else begin : g_pad
            assign w_bound[k] = '1;
        end
    end

    assign w_next_bound = w_bound[idx_q];
    assign w_can_step   = (idx_q < c_last_idx);
    assign w_hit_h      = (pix_y == w_next_bound);
    assign w_hit_v      = (({1'b0, pix_x} + 11'd1) == {1'b0, w_next_bound});

    always_comb begin
        idx_d = idx_q;
        if (VERTICAL != 0) begin
            if (line_start) begin
                idx_d = '0;
            end else if (w_can_step && w_hit_v) begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            if (line_start && (pix_y == '0)) begin
                idx_d = '0;
            end else if (line_start && w_can_step && w_hit_h) begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Clears and row steps land on the line_start pixel itself, so that pixel
    // already belongs to the new band; column steps are looked ahead by one.
    assign idx = line_start ? idx_d : idx_q;

endmodule : flag_stripe_tracker
`default_nettype wire

// File: rtl/flag_stripe_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_stripe_engine : striped flag pixel generator with optional 50%      |
// |                      dither per band. FLAG_TEMPORAL_DITHER_EN flips the  |
// |                      dither checkerboard every frame.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module flag_stripe_engine
    import flag_pkg::*;
#(
    parameter int          NUM_STRIPES = 7,
    parameter int          SPAN        = 480,
    parameter int          VERTICAL    = 0,
    parameter logic [47:0] COLOR_A     = 48'h0,
    parameter logic [47:0] COLOR_B     = 48'h0,
    parameter logic [7:0]  DITHER_MASK = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [POS_W-1:0]   pix_x,
    input  logic [POS_W-1:0]   pix_y,
    input  logic               video_active,
    input  logic               line_start,
    input  logic               frame_start,
    output logic [COLOR_W-1:0] color
);

    logic [IDX_W-1:0]   w_idx;
    logic               w_phase;
    logic               w_dither;
    logic [COLOR_W-1:0] w_primary;
    logic [COLOR_W-1:0] w_secondary;
    logic [COLOR_W-1:0] color_d;
    logic [COLOR_W-1:0] color_q;

    flag_stripe_tracker #(
        .NUM_STRIPES (NUM_STRIPES),
        .SPAN        (SPAN),
        .VERTICAL    (VERTICAL)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_start (line_start),
        .idx        (w_idx)
    );

`ifdef FLAG_TEMPORAL_DITHER_EN
    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = frame_start ? ~phase_q : phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // The frame_start pixel already uses the new frame's checkerboard.
    assign w_phase = phase_d;
`else
    logic w_unused_frame_start;

    assign w_unused_frame_start = frame_start;
    assign w_phase              = 1'b0;
`endif

    assign w_primary   = COLOR_A[COLOR_W*int'(w_idx) +: COLOR_W];
    assign w_secondary = COLOR_B[COLOR_W*int'(w_idx) +: COLOR_W];
    assign w_dither    = DITHER_MASK[w_idx] & (pix_x[0] ^ pix_y[0] ^ w_phase);

    always_comb begin
        color_d = BLACK;
        if (video_active) begin
            color_d = w_dither ? w_secondary : w_primary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= BLACK;
        end else begin
            color_q <= color_d;
        end
    end

    assign color = color_q;

endmodule : flag_stripe_engine
`default_nettype wire

// File: tb/tb_flag_stripe_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flag_stripe_engine : scoreboard bench for a 7-band horizontal engine  |
// |                         and a 4-band vertical engine on shared timing.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_flag_stripe_engine;
    import flag_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_active;
    logic       line_start;
    logic       frame_start;
    logic [5:0] color_h;
    logic [5:0] color_v;

    always #5 clk = ~clk;

    flag_stripe_engine #(
        .NUM_STRIPES (7),
        .SPAN        (480),
        .VERTICAL    (0),
        .COLOR_A     ({6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h34}),
        .COLOR_B     ({6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h24}),
        .DITHER_MASK (8'h01)
    ) dut_h (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .color        (color_h)
    );

    flag_stripe_engine #(
        .NUM_STRIPES (4),
        .SPAN        (640),
        .VERTICAL    (1),
        .COLOR_A     ({24'h0, GREEN, BLUE, WHITE, RED}),
        .COLOR_B     (48'hFFFF_FFFF_FFFF),
        .DITHER_MASK (8'h00)
    ) dut_v (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .color        (color_v)
    );

    // Hand-computed band starts: floor(480*k/7).
    localparam int         H_START [7] = '{0, 68, 137, 205, 274, 342, 411};
    localparam logic [5:0] H_A     [7] = '{6'h34, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    localparam logic [5:0] H_B0        = 6'h24;
    localparam logic [5:0] V_A     [4] = '{6'b110000, 6'b111111, 6'b000011, 6'b001100};

    typedef struct {
        bit         ch;
        logic [5:0] eh;
        bit         cv;
        logic [5:0] ev;
        int         x;
        int         y;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   ph    = 1'b0;
    bit   resync = 1'b0;

    function automatic int band_h(input int y);
        int b = 0;
        for (int k = 1; k < 7; k++) begin
            if (y >= H_START[k]) b = k;
        end
        return b;
    endfunction

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp,
                         input int x, input int y);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at x=%0d y=%0d: got %b, expected %b", nm, x, y, got, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input bit act, input bit ls,
                         input bit fs, input bit chk_h, input bit chk_v);
        exp_t e;
        int   b;
        @(negedge clk);
        pix_x        = 10'(x);
        pix_y        = 10'(y);
        video_active = act;
        line_start   = ls;
        frame_start  = fs;
        if (fs) begin
            resync = 1'b0;
`ifdef FLAG_TEMPORAL_DITHER_EN
            ph = ~ph;
`endif
        end
        b    = resync ? 0 : band_h(y);
        e.ch = chk_h;
        e.cv = chk_v;
        e.x  = x;
        e.y  = y;
        if (!act)                                   e.eh = 6'h00;
        else if (b == 0 && ((x % 2) ^ (y % 2) ^ int'(ph)) == 1) e.eh = H_B0;
        else                                        e.eh = H_A[b];
        e.ev = act ? V_A[x / 160] : 6'h00;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_h", color_h, 6'h00, int'(pix_x), int'(pix_y));
        check("async_reset_v", color_v, 6'h00, int'(pix_x), int'(pix_y));
        ph     = 1'b0;
        resync = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Short 8-pixel lines keep frames cheap; x=7 is blanked on every line.
    task automatic run_frame(input int rst_row);
        for (int y = 0; y < 480; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (y == rst_row && x == 3) begin
                    do_reset();
                    break;
                end
                drive(x, y, x < 7, x == 0, x == 0 && y == 0, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ch) check("h_pixel", color_h, e.eh, e.x, e.y);
                if (e.cv) check("v_pixel", color_v, e.ev, e.x, e.y);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

    initial begin : stimulus
        rst_n        = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        video_active = 1'b0;
        line_start   = 1'b0;
        frame_start  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_h", color_h, 6'h00, 0, 0);
        check("reset_v", color_v, 6'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(-1);
        run_frame(-1);
        run_frame(200);
        run_frame(-1);

        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < 640; x++) begin
                drive(x, 5, 1'b1, x == 0, 1'b0, 1'b0, 1'b1);
            end
        end

        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected pixels left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_flag_stripe_engine
`default_nettype wire
